// File: rtl/bus_pkg.sv
// Shared constants and helpers for the multi-master memory bus interconnect.
package bus_pkg;

    localparam logic [1:0] IO_REGION = 2'b11;
    localparam int         IO_SEL_W  = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Master-index width; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible request after ptr.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     grant
);

    logic [N-1:0] cand_s;

    assign cand_s = req & mask;

    // Circular search starting just after the last-served master.
    always_comb begin
        logic [IDX_W:0]   sum_s;
        logic [IDX_W-1:0] idx_s;
        logic             found_s;
        grant   = {N{1'b0}};
        found_s = 1'b0;
        sum_s   = {(IDX_W+1){1'b0}};
        idx_s   = {IDX_W{1'b0}};
        for (int i = 1; i <= N; i++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(N)) begin
                sum_s = sum_s - (IDX_W+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (!found_s && cand_s[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master byte-bus interconnect to RAM and memory-mapped I/O with priority,
// bus locking, I/O write back-pressure and registered read-return steering.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int PRIO_MASTER    = N_MASTERS - 1,
    parameter bit IO_STALL_EN    = 1'b1
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_lock,
    input  logic [N_MASTERS-1:0]            m_wr,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [N_MASTERS*8-1:0]          m_dout,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [N_MASTERS-1:0]            m_rvalid,
    output logic [7:0]                      m_din,
    output logic                            ram_en,
    output logic                            ram_r_nw,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_a,
    output logic [7:0]                      ram_d_out,
    input  logic [7:0]                      ram_d_in,
    output logic                            io_en,
    output logic [IO_SEL_W-1:0]             io_sel,
    output logic                            io_wr,
    output logic [7:0]                      io_d_out,
    input  logic [7:0]                      io_d_in,
    input  logic                            io_full
);

    localparam int                IDX_W    = idx_width(N_MASTERS);
    localparam logic [IDX_W-1:0]  PRIO_IDX = IDX_W'(PRIO_MASTER);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0]      rr_ptr_r;
    logic                  locked_r;
    logic [IDX_W-1:0]      lock_owner_r;
    logic                  q_rd_r;
    logic                  q_io_r;
    logic [IDX_W-1:0]      q_idx_r;

    logic [N_MASTERS-1:0]  mask_s;
    logic [N_MASTERS-1:0]  rr_grant_s;
    logic [N_MASTERS-1:0]  grant_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [7:0]            sel_dout_s;
    logic                  sel_wr_s;
    logic                  sel_lock_s;
    logic                  is_io_s;
    logic                  accept_s;
    logic                  unused_addr_bits_s;

    // While locked only the owner is eligible in the round-robin search.
    assign mask_s = locked_r ? (ONE_HOT0 << lock_owner_r) : {N_MASTERS{1'b1}};

    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (m_req),
        .ptr   (rr_ptr_r),
        .mask  (mask_s),
        .grant (rr_grant_s)
    );

    // Final grant: priority master overrides lock and rotation; none during reset.
    always_comb begin
        grant_s = {N_MASTERS{1'b0}};
        if (rst_in) begin
            grant_s = {N_MASTERS{1'b0}};
        end else if (m_req[PRIO_MASTER]) begin
            grant_s[PRIO_MASTER] = 1'b1;
        end else begin
            grant_s = rr_grant_s;
        end
    end

    // One-hot mux of the granted master's request fields.
    always_comb begin
        gnt_idx_s  = {IDX_W{1'b0}};
        sel_addr_s = {ADDR_WIDTH{1'b0}};
        sel_dout_s = 8'h00;
        sel_wr_s   = 1'b0;
        sel_lock_s = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            gnt_idx_s  = gnt_idx_s  | (IDX_W'(i) & {IDX_W{grant_s[i]}});
            sel_addr_s = sel_addr_s | (m_a[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
            sel_dout_s = sel_dout_s | (m_dout[i*8 +: 8] & {8{grant_s[i]}});
            sel_wr_s   = sel_wr_s   | (m_wr[i] & grant_s[i]);
            sel_lock_s = sel_lock_s | (m_lock[i] & grant_s[i]);
        end
    end

    assign is_io_s  = (sel_addr_s[RAM_ADDR_WIDTH -: 2] == IO_REGION);
    assign accept_s = (|grant_s) && !(IO_STALL_EN && is_io_s && sel_wr_s && io_full);
    assign unused_addr_bits_s = ^sel_addr_s;

    // Arbitration, lock and read-return state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr_r     <= IDX_W'(N_MASTERS - 1);
            locked_r     <= 1'b0;
            lock_owner_r <= {IDX_W{1'b0}};
            q_rd_r       <= 1'b0;
            q_io_r       <= 1'b0;
            q_idx_r      <= {IDX_W{1'b0}};
        end else begin
            q_rd_r <= accept_s && !sel_wr_s;
            if (accept_s) begin
                rr_ptr_r <= gnt_idx_s;
                q_io_r   <= is_io_s;
                q_idx_r  <= gnt_idx_s;
                if (gnt_idx_s != PRIO_IDX) begin
                    locked_r     <= sel_lock_s;
                    lock_owner_r <= gnt_idx_s;
                end else begin
                    locked_r     <= locked_r;
                    lock_owner_r <= lock_owner_r;
                end
            end else begin
                rr_ptr_r <= rr_ptr_r;
                q_io_r   <= q_io_r;
                q_idx_r  <= q_idx_r;
            end
        end
    end

    // Transfer strobes toward RAM / I/O and the acknowledge back to the master.
    always_comb begin
        m_ack     = {N_MASTERS{1'b0}};
        ram_en    = 1'b0;
        ram_r_nw  = 1'b1;
        ram_a     = {RAM_ADDR_WIDTH{1'b0}};
        ram_d_out = 8'h00;
        io_en     = 1'b0;
        io_sel    = {IO_SEL_W{1'b0}};
        io_wr     = 1'b0;
        io_d_out  = 8'h00;
        if (accept_s) begin
            m_ack = grant_s;
            if (is_io_s) begin
                io_en    = 1'b1;
                io_sel   = sel_addr_s[IO_SEL_W-1:0];
                io_wr    = sel_wr_s;
                io_d_out = sel_wr_s ? sel_dout_s : 8'h00;
            end else begin
                ram_en    = 1'b1;
                ram_r_nw  = !sel_wr_s;
                ram_a     = sel_addr_s[RAM_ADDR_WIDTH-1:0];
                ram_d_out = sel_wr_s ? sel_dout_s : 8'h00;
            end
        end else begin
            m_ack = {N_MASTERS{1'b0}};
        end
    end

    // Read return is steered purely from the registered q_* state.
    always_comb begin
        m_rvalid = {N_MASTERS{1'b0}};
        m_din    = 8'h00;
        if (q_rd_r && !rst_in) begin
            m_rvalid = ONE_HOT0 << q_idx_r;
            m_din    = q_io_r ? io_d_in : ram_d_in;
        end else begin
            m_rvalid = {N_MASTERS{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter with three masters (master 2 = priority).
module tb_mem_bus_arbiter;

    localparam int N = 3;
    localparam logic [31:0] RA  = 32'h0000_0100; // RAM byte 0x00^0x5A = 0x5A
    localparam logic [31:0] RB  = 32'h0000_0155; // 0x55^0x5A = 0x0F
    localparam logic [31:0] RC  = 32'h0000_0233; // 0x33^0x5A = 0x69
    localparam logic [31:0] RD  = 32'h0000_02F0; // 0xF0^0x5A = 0xAA
    localparam logic [31:0] IOW = 32'h0003_0000;
    localparam logic [31:0] IOR = 32'h0003_0004;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_req, m_lock, m_wr, m_ack, m_rvalid;
    logic [N*32-1:0] m_a;
    logic [N*8-1:0]  m_dout;
    logic [7:0]    m_din, ram_d_out, ram_d_in, io_d_out, io_d_in;
    logic          ram_en, ram_r_nw, io_en, io_wr, io_full;
    logic [16:0]   ram_a;
    logic [2:0]    io_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  req, lock, wr;
        logic [31:0] a0, a1, a2;
        logic [7:0]  d0;
        logic        full;
        logic [2:0]  ack, rv;
        logic [7:0]  din;
        logic        ram_en, io_en, io_wr;
        logic [2:0]  sel;
        logic [7:0]  wdata;
    } vec_t;

    vec_t tbl[$];

    mem_bus_arbiter #(
        .N_MASTERS      (N),
        .ADDR_WIDTH     (32),
        .RAM_ADDR_WIDTH (17),
        .PRIO_MASTER    (2),
        .IO_STALL_EN    (1'b1)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .m_req     (m_req),
        .m_lock    (m_lock),
        .m_wr      (m_wr),
        .m_a       (m_a),
        .m_dout    (m_dout),
        .m_ack     (m_ack),
        .m_rvalid  (m_rvalid),
        .m_din     (m_din),
        .ram_en    (ram_en),
        .ram_r_nw  (ram_r_nw),
        .ram_a     (ram_a),
        .ram_d_out (ram_d_out),
        .ram_d_in  (ram_d_in),
        .io_en     (io_en),
        .io_sel    (io_sel),
        .io_wr     (io_wr),
        .io_d_out  (io_d_out),
        .io_d_in   (io_d_in),
        .io_full   (io_full)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory models with address-derived data.
    always @(posedge clk) begin
        ram_d_in <= ram_a[7:0] ^ 8'h5A;
        io_d_in  <= 8'hC0 | {5'b00000, io_sel};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] lock, input logic [2:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [7:0] d0, input logic full);
        m_req   = req;
        m_lock  = lock;
        m_wr    = wr;
        m_a     = {a2, a1, a0};
        m_dout  = {8'h00, 8'h00, d0};
        io_full = full;
    endtask

    function automatic vec_t v(input logic [2:0] req, input logic [2:0] lock, input logic [2:0] wr,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [7:0] d0, input logic full, input logic [2:0] ack,
                               input logic [2:0] rv, input logic [7:0] din, input logic ram_e,
                               input logic io_e, input logic io_w, input logic [2:0] sel,
                               input logic [7:0] wdata);
        vec_t r;
        r.req = req; r.lock = lock; r.wr = wr; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.full = full; r.ack = ack; r.rv = rv; r.din = din;
        r.ram_en = ram_e; r.io_en = io_e; r.io_wr = io_w; r.sel = sel; r.wdata = wdata;
        return r;
    endfunction

    initial begin
        // Round-robin between masters 0 and 1 (reads), then drain.
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b001, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b010, 3'b001, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b001, 3'b010, 8'h0F, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b010, 3'b001, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b000, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b000, 3'b010, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        // Master 1 locks; priority master 2 cuts in; lock still excludes master 0.
        tbl.push_back(v(3'b010, 3'b010, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b010, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b111, 3'b010, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b100, 3'b010, 8'h69, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b010, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b010, 3'b100, 8'hAA, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b010, 3'b010, 8'h69, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b001, 3'b010, 8'h69, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b000, 3'b000, 3'b000, RA, RC, RD, 8'h00, 1'b0, 3'b000, 3'b001, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        // I/O write stalled by io_full for three cycles, then accepted.
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(3'b001, 3'b000, 3'b001, IOW, 32'h0, 32'h0, 8'h41, 1'b1, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b001, 3'b000, 3'b001, IOW, 32'h0, 32'h0, 8'h41, 1'b0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h41));
        // I/O read, then a RAM read accepted in the I/O return cycle.
        tbl.push_back(v(3'b001, 3'b000, 3'b000, IOR, RB, 32'h0, 8'h00, 1'b0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00));
        tbl.push_back(v(3'b010, 3'b000, 3'b000, IOR, RB, 32'h0, 8'h00, 1'b0, 3'b010, 3'b001, 8'hC4, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b000, 3'b000, 3'b000, IOR, RB, 32'h0, 8'h00, 1'b0, 3'b000, 3'b010, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        // Locked burst of four reads by master 0 while master 1 waits.
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(3'b011, 3'b001, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b001, (i == 0) ? 3'b000 : 3'b001, (i == 0) ? 8'h00 : 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b001, 3'b001, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b010, 3'b001, 8'h5A, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        tbl.push_back(v(3'b000, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0, 3'b000, 3'b010, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));

        // Reset state: requests present but nothing granted.
        rst = 1'b1;
        drive(3'b111, 3'b000, 3'b000, RA, RB, RD, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset ack", 32'(m_ack), 32'h0);
        chk("reset rvalid", 32'(m_rvalid), 32'h0);
        chk("reset ram_en", 32'(ram_en), 32'h0);
        chk("reset io_en", 32'(io_en), 32'h0);
        chk("reset ram_r_nw", 32'(ram_r_nw), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].req, tbl[k].lock, tbl[k].wr, tbl[k].a0, tbl[k].a1, tbl[k].a2, tbl[k].d0, tbl[k].full);
            @(negedge clk);
            chk($sformatf("row%0d ack", k), 32'(m_ack), 32'(tbl[k].ack));
            chk($sformatf("row%0d rvalid", k), 32'(m_rvalid), 32'(tbl[k].rv));
            if (tbl[k].rv != 3'b000) chk($sformatf("row%0d din", k), 32'(m_din), 32'(tbl[k].din));
            chk($sformatf("row%0d ram_en", k), 32'(ram_en), 32'(tbl[k].ram_en));
            chk($sformatf("row%0d io_en", k), 32'(io_en), 32'(tbl[k].io_en));
            chk($sformatf("row%0d io_wr", k), 32'(io_wr), 32'(tbl[k].io_wr));
            if (tbl[k].io_en) chk($sformatf("row%0d io_sel", k), 32'(io_sel), 32'(tbl[k].sel));
            if (tbl[k].io_wr) chk($sformatf("row%0d io_d_out", k), 32'(io_d_out), 32'(tbl[k].wdata));
            @(posedge clk);
            #1;
        end

        // Reset during a return cycle: read dropped, pointer back to N-1.
        drive(3'b001, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pre-reset ack", 32'(m_ack), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(3'b011, 3'b000, 3'b000, RA, RB, 32'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("in-reset ack", 32'(m_ack), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset rvalid", 32'(m_rvalid), 32'h0);
        chk("post-reset ack", 32'(m_ack), 32'h1);
        @(posedge clk);
        #1;

        // RAM write path.
        drive(3'b001, 3'b000, 3'b001, 32'h0000_0123, 32'h0, 32'h0, 8'h9C, 1'b0);
        @(negedge clk);
        chk("ramwr ack", 32'(m_ack), 32'h1);
        chk("ramwr ram_en", 32'(ram_en), 32'h1);
        chk("ramwr ram_r_nw", 32'(ram_r_nw), 32'h0);
        chk("ramwr ram_a", 32'(ram_a), 32'h123);
        chk("ramwr ram_d_out", 32'(ram_d_out), 32'h9C);
        @(posedge clk);
        #1;
        drive(3'b000, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
        @(negedge clk);
        chk("ramwr no rvalid", 32'(m_rvalid), 32'h0);
        chk("idle ram_r_nw", 32'(ram_r_nw), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised multi-master byte-bus interconnect between N bus masters (CPU load/store unit, instruction fetch, HCI debug port) and the shared 128 KiB RAM plus memory-mapped I/O. It sits in `riscv_top` and replaces the fixed two-way `hci_active` mux. It adds:
- round-robin arbitration with one absolute-priority master;
- bus locking for multi-byte accesses;
- I/O-full write back-pressure;
- per-master registered read-return steering.

## Interface
Parameters:
- `N_MASTERS`, 2, number of masters (2..8).
- `ADDR_WIDTH`, 32, master address width.
- `RAM_ADDR_WIDTH`, 17, RAM address width.
- `PRIO_MASTER`, `N_MASTERS-1`, index of the absolute-priority (debug) master.
- `IO_STALL_EN`, 1, stall I/O writes while `io_full`=1.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  in  1  clock
- `rst_in`  in  1  synchronous active-high reset
- `m_req`  in  N_MASTERS  transfer request, held until acked
- `m_lock`  in  N_MASTERS  keep bus ownership after this transfer
- `m_wr`  in  N_MASTERS  1=write, 0=read
- `m_a`  in  N_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `m_dout`  in  N_MASTERS*8  packed write data
- `m_ack`  out  N_MASTERS  one-hot, transfer accepted this cycle
- `m_rvalid`  out  N_MASTERS  one-hot, read data valid on `m_din`
- `m_din`  out  8  shared read data
- `ram_en`  out  1  RAM enable
- `ram_r_nw`  out  1  RAM 1=read
- `ram_a`  out  RAM_ADDR_WIDTH  RAM address
- `ram_d_out`  out  8  RAM write data
- `ram_d_in`  in  8  RAM read data, 1-cycle latency
- `io_en`  out  1  I/O access strobe
- `io_sel`  out  3  I/O register select = addr[2:0]
- `io_wr`  out  1  I/O write
- `io_d_out`  out  8  I/O write data
- `io_d_in`  in  8  I/O read data, 1-cycle latency
- `io_full`  in  1  I/O output buffer full

## Operation
- **Decode.** An address is I/O when addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11; otherwise it is RAM, with `ram_a` = addr[RAM_ADDR_WIDTH-1:0].
- **Grant** (combinational, at most one per cycle):
  1. `PRIO_MASTER` wins if it requests, even against a lock.
  2. Otherwise, if `locked`, only `lock_owner` may be granted; other requests wait.
  3. Otherwise round-robin: search starts at `rr_ptr+1` mod N.
- **Accept.** A granted transfer is accepted (`m_ack`=1, `ram_en` or `io_en`=1) unless all of the following hold:
  - `IO_STALL_EN`=1,
  - the target is I/O,
  - `m_wr`=1,
  - `io_full`=1.
  
  In the stalled case there is no ack and no strobe, and the master retries next cycle.
- **On accept:**
  - `rr_ptr` ← granted index.
  - `locked` ← `m_lock[g]`, `lock_owner` ← g. The priority master's transfer leaves the existing lock state untouched.
- **Read return.** On an accepted read, register `q_io` (target was I/O), `q_idx`=g and `q_rd`=1. The next cycle:
  - `m_din` = `q_io` ? `io_d_in` : `ram_d_in`;
  - `m_rvalid[q_idx]`=1.
- **Idle.** With no accept, all strobes are 0 and `ram_r_nw`=1.
- **Reset.** `rr_ptr`=N_MASTERS-1, `locked`=0, `lock_owner`=0, `q_rd`=0, `q_io`=0. Combinational outputs are low during reset; `ram_r_nw` is 1.

## Timing
- Grant and strobes are combinational from `m_req`/`m_a`/`io_full` and the registered state. There is no added cycle for a request.
- Read data arrives exactly 1 cycle after `m_ack`. A new transfer may be accepted in that same cycle (fully pipelined, 1 transfer/cycle).
- `m_rvalid` and the `m_din` steering are driven only from registered `q_*`. A decode change in the return cycle must not corrupt returned data.
- **Lock handover.** Lock release is effective the cycle after an accepted transfer with `m_lock`=0.
- **Owner drop.** If the lock owner deasserts `m_req` while locked, the bus stays locked and other masters starve; owners must finish with a `m_lock`=0 transfer.
- **Reset mid-read.** If `rst_in` is asserted in the return cycle, `m_rvalid` is 0 in the following cycle; the pending read is dropped.

## Structure
- Shared package `bus_pkg`: IO region constant 2'b11, `IO_SEL_W`=3, and the master-index width function clog2(N_MASTERS).
- One natural sub-module: `rr_arbiter` (N-bit request, pointer, and mask inputs; one-hot grant). Lock masking and the priority override live in the parent.

## Test plan
- **Round-robin:** N=3, `PRIO_MASTER`=2. Masters 0 and 1 request reads to 0x100 continuously → acks alternate 0,1,0,1; each `m_rvalid` fires one cycle after its ack with the RAM byte.
- **Priority:** master 1 holds a lock at 0x200; master 2 requests → master 2 acked that cycle; master 1 is acked next; the lock is still held against master 0.
- **I/O stall:** master 0 writes 0x30000 with data 0x41 and `io_full`=1 for 3 cycles → no ack and `io_en`=0 for those 3 cycles. After `io_full` drops, the same cycle gives ack=1, `io_wr`=1, `io_sel`=0, `io_d_out`=0x41.
- **I/O read steering:** read 0x30004 → `io_sel`=4. In the next cycle `m_din`=`io_d_in` even though a RAM read is accepted in that cycle. The RAM data returns the cycle after.
- **Lock sequence:** master 0 issues 4 reads with lock=1,1,1,0 while master 1 requests → master 1 is not acked until the cycle after the 4th ack.
- **Reset:** assert `rst_in` during a return cycle → `m_rvalid`=0, `m_ack`=0, and after release the first grant is to master 0.
